// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the
// data-memory responder and its wait counter.
package dmem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_MMIO_REQ,
    S_MMIO_RSP,
    S_RESP
  } dmem_state_t;

  localparam logic [3:0]  MMIO_TAG_DEF  = 4'hF;
  localparam logic [31:0] DMEM_BAD_DATA = 32'hDEAD_BEEF;

  // Byte, aligned half-word and word enables only.
  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                   be_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_wait_ctr.sv
// dmem_wait_ctr: loadable down-counter that
// saturates at zero; zero flags expiry.
module dmem_wait_ctr
  import dmem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         Rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load wins over decrement; hold at zero once expired.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: core data port front-end that
// steers accesses to a fixed-latency SRAM or MMIO.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int         ADDR_W   = 12,
  parameter int         RD_LAT   = 2,
  parameter logic [3:0] MMIO_TAG = MMIO_TAG_DEF,
  parameter int         TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              mem_rea,
  input  logic              mem_wea,
  input  logic [3:0]        mem_en,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_din,
  output logic [31:0]       mem_dout,
  output logic              mem_hold,
  output logic              err,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              mmio_req_valid,
  input  logic              mmio_req_ready,
  output logic              mmio_we,
  output logic [3:0]        mmio_be,
  output logic [7:0]        mmio_addr,
  output logic [31:0]       mmio_wdata,
  input  logic              mmio_rsp_valid,
  input  logic [31:0]       mmio_rdata
);

  localparam int TW =
    (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LOAD =
    TW'(TIMEOUT - 1);
  localparam logic [2:0] RD_LOAD =
    3'(RD_LAT - 1);

  dmem_state_t state;
  logic [31:0] dout_q;

  logic idle, req, legal, is_mmio;
  logic bad, go_rd, go_wr, go_mmio;
  logic rd_zero, to_zero;
  logic to_load, to_en;
  logic unused_addr;

  // Idle decode is masked during reset so a held
  // request cannot raise hold or touch the SRAM.
  assign idle    = (state == S_IDLE) && !Rst;
  assign req     = mem_rea | mem_wea;
  assign legal   = be_legal(mem_en)
                 && !(mem_rea && mem_wea);
  assign is_mmio = (mem_addr[31:28] == MMIO_TAG);

  assign bad     = idle && req && !legal;
  assign go_mmio = idle && req && legal && is_mmio;
  assign go_rd   = idle && mem_rea && legal
                 && !is_mmio;
  assign go_wr   = idle && mem_wea && legal
                 && !is_mmio;

  assign ram_en    = go_rd | go_wr;
  assign ram_we    = go_wr ? mem_en : 4'h0;
  assign ram_addr  = ram_en
                   ? mem_addr[ADDR_W+1:2] : '0;
  assign ram_wdata = go_wr ? mem_din : 32'h0;

  assign mem_hold = go_rd | go_mmio
                  | (state == S_RD_WAIT)
                  | (state == S_MMIO_REQ)
                  | (state == S_MMIO_RSP);

  assign mem_dout = (state == S_RESP)
                  ? dout_q : 32'h0;

  assign unused_addr = ^mem_addr;

  // Timeout reloads on entry to each MMIO phase.
  assign to_load = go_mmio
                 | ((state == S_MMIO_REQ)
                    && mmio_req_ready);
  assign to_en   = (state == S_MMIO_REQ)
                 | (state == S_MMIO_RSP);

  dmem_wait_ctr #(.W(3)) u_rd_ctr (
    .clk      (clk),
    .Rst      (Rst),
    .load     (go_rd),
    .load_val (RD_LOAD),
    .en       (state == S_RD_WAIT),
    .zero     (rd_zero)
  );

  dmem_wait_ctr #(.W(TW)) u_to_ctr (
    .clk      (clk),
    .Rst      (Rst),
    .load     (to_load),
    .load_val (TO_LOAD),
    .en       (to_en),
    .zero     (to_zero)
  );

  // Main FSM with registered err, dout and MMIO bus.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state          <= S_IDLE;
      dout_q         <= 32'h0;
      err            <= 1'b0;
      mmio_req_valid <= 1'b0;
      mmio_we        <= 1'b0;
      mmio_be        <= 4'h0;
      mmio_addr      <= 8'h0;
      mmio_wdata     <= 32'h0;
    end else begin
      err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bad) begin
            err <= 1'b1;
          end else if (go_mmio) begin
            mmio_we        <= mem_wea;
            mmio_be        <= mem_en;
            mmio_addr      <= mem_addr[7:0];
            mmio_wdata     <= mem_din;
            mmio_req_valid <= 1'b1;
            state          <= S_MMIO_REQ;
          end else if (go_rd) begin
            state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (rd_zero) begin
            dout_q <= ram_rdata;
            state  <= S_RESP;
          end
        end
        S_MMIO_REQ: begin
          if (mmio_req_ready) begin
            mmio_req_valid <= 1'b0;
            state          <= S_MMIO_RSP;
          end else if (to_zero) begin
            mmio_req_valid <= 1'b0;
            err            <= 1'b1;
            dout_q         <= DMEM_BAD_DATA;
            state          <= S_RESP;
          end
        end
        S_MMIO_RSP: begin
          if (mmio_rsp_valid) begin
            dout_q <= mmio_we ? 32'h0 : mmio_rdata;
            state  <= S_RESP;
          end else if (to_zero) begin
            err    <= 1'b1;
            dout_q <= DMEM_BAD_DATA;
            state  <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench with a dout
// scoreboard; RD_LAT=2 and RD_LAT=1 instances.
module tb_dmem_responder;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        mem_rea = 1'b0;
  logic        mem_wea = 1'b0;
  logic [3:0]  mem_en = 4'h0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_din = 32'h0;
  logic        mmio_req_ready = 1'b0;
  logic        mmio_rsp_valid = 1'b0;
  logic [31:0] mmio_rdata = 32'h0;

  logic [31:0] a_dout, b_dout;
  logic        a_hold, b_hold, a_err, b_err;
  logic        a_ram_en, b_ram_en;
  logic [3:0]  a_ram_we, b_ram_we;
  logic [11:0] a_ram_addr, b_ram_addr;
  logic [31:0] a_ram_wdata, b_ram_wdata;
  logic [31:0] a_ram_rdata, b_ram_rdata;
  logic        a_req_valid, b_req_valid;
  logic        a_mmio_we, b_mmio_we;
  logic [3:0]  a_mmio_be, b_mmio_be;
  logic [7:0]  a_mmio_addr, b_mmio_addr;
  logic [31:0] a_mmio_wdata, b_mmio_wdata;

  logic [31:0] mem [0:4095];
  logic [31:0] a_pipe0, a_pipe1, b_pipe0;
  logic [31:0] exp_q [$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.RD_LAT(2), .TIMEOUT(TO)) u_a (
    .clk(clk), .Rst(Rst),
    .mem_rea(mem_rea), .mem_wea(mem_wea),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(a_dout),
    .mem_hold(a_hold), .err(a_err),
    .ram_en(a_ram_en), .ram_we(a_ram_we),
    .ram_addr(a_ram_addr),
    .ram_wdata(a_ram_wdata),
    .ram_rdata(a_ram_rdata),
    .mmio_req_valid(a_req_valid),
    .mmio_req_ready(mmio_req_ready),
    .mmio_we(a_mmio_we), .mmio_be(a_mmio_be),
    .mmio_addr(a_mmio_addr),
    .mmio_wdata(a_mmio_wdata),
    .mmio_rsp_valid(mmio_rsp_valid),
    .mmio_rdata(mmio_rdata)
  );

  dmem_responder #(.RD_LAT(1), .TIMEOUT(TO)) u_b (
    .clk(clk), .Rst(Rst),
    .mem_rea(mem_rea), .mem_wea(mem_wea),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(b_dout),
    .mem_hold(b_hold), .err(b_err),
    .ram_en(b_ram_en), .ram_we(b_ram_we),
    .ram_addr(b_ram_addr),
    .ram_wdata(b_ram_wdata),
    .ram_rdata(b_ram_rdata),
    .mmio_req_valid(b_req_valid),
    .mmio_req_ready(mmio_req_ready),
    .mmio_we(b_mmio_we), .mmio_be(b_mmio_be),
    .mmio_addr(b_mmio_addr),
    .mmio_wdata(b_mmio_wdata),
    .mmio_rsp_valid(mmio_rsp_valid),
    .mmio_rdata(mmio_rdata)
  );

  // SRAM model: byte writes from instance a; a
  // filler word marks cycles with no read data.
  always @(posedge clk) begin
    if (a_ram_en && a_ram_we != 4'h0) begin
      for (int k = 0; k < 4; k++)
        if (a_ram_we[k])
          mem[a_ram_addr][8*k +: 8] <=
            a_ram_wdata[8*k +: 8];
    end
  end

  always @(posedge clk) begin
    a_pipe0 <= (a_ram_en && a_ram_we == 4'h0)
             ? mem[a_ram_addr] : 32'h5A5A_5A5A;
    a_pipe1 <= a_pipe0;
    b_pipe0 <= (b_ram_en && b_ram_we == 4'h0)
             ? mem[b_ram_addr] : 32'h5A5A_5A5A;
  end

  assign a_ram_rdata = a_pipe1;
  assign b_ram_rdata = b_pipe0;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    mem_rea = 1'b0;
    mem_wea = 1'b0;
    mem_en  = 4'h0;
    mem_addr = 32'h0;
    mem_din = 32'h0;
    mmio_req_ready = 1'b0;
    mmio_rsp_valid = 1'b0;
  endtask

  // Walks hold cycles until release; counts hold
  // and ram_en cycles including the release cycle.
  task automatic wait_resp(input bit use_b,
                           output int holds,
                           output int ens);
    bit done;
    done = 1'b0;
    holds = 0;
    ens = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      ens += int'(use_b ? b_ram_en : a_ram_en);
      if (use_b ? b_hold : a_hold) begin
        holds++;
        cyc();
        #1;
      end else begin
        done = 1'b1;
      end
    end
    n_tests++;
    assert (done) else begin
      n_fail++;
      $error("FAIL resp_wait: observed %0d %s",
             holds, "hold cycles, expected release");
    end
  endtask

  logic [31:0] wa [5] = '{32'h10, 32'h14, 32'h14,
                          32'h0, 32'h4};
  logic [3:0]  wb [5] = '{4'hF, 4'hF, 4'h3,
                          4'hF, 4'hF};
  logic [31:0] wd [5] = '{32'hCAFE_F00D,
                          32'hFFFF_FFFF,
                          32'h1234_5678,
                          32'h1111_2222,
                          32'h3333_4444};

  int holds, ens, vcnt, resp_c, err_c, err_n;
  logic [31:0] expv;

  initial begin
    idle_bus();
    Rst = 1'b1;
    cyc();
    cyc();
    #1;
    check("rst_hold", a_hold, 0);
    check("rst_dout", a_dout, 0);
    check("rst_err", a_err, 0);
    check("rst_valid", a_req_valid, 0);
    check("rst_mmio_addr", a_mmio_addr, 0);
    Rst = 1'b0;

    // Posted writes, one per cycle.
    for (int i = 0; i < 5; i++) begin
      cyc();
      mem_wea = 1'b1;
      mem_en = wb[i];
      mem_addr = wa[i];
      mem_din = wd[i];
      #1;
      check("wr_ram_en", a_ram_en, 1);
      check("wr_ram_we", a_ram_we, wb[i]);
      check("wr_ram_addr", a_ram_addr, wa[i] >> 2);
      check("wr_wdata", a_ram_wdata, wd[i]);
      check("wr_hold", a_hold, 0);
    end

    // Reads with RD_LAT=2: three hold cycles.
    cyc();
    idle_bus();
    mem_rea = 1'b1;
    mem_en = 4'hF;
    mem_addr = 32'h10;
    exp_q.push_back(32'hCAFE_F00D);
    #1;
    wait_resp(1'b0, holds, ens);
    check("rd2_holds", holds, 3);
    check("rd2_ram_en", ens, 1);
    expv = exp_q.pop_front();
    check("rd2_dout", a_dout, expv);

    cyc();
    mem_addr = 32'h14;
    exp_q.push_back(32'hFFFF_5678);
    #1;
    wait_resp(1'b0, holds, ens);
    check("rd2b_holds", holds, 3);
    expv = exp_q.pop_front();
    check("rd2b_dout", a_dout, expv);

    // MMIO write, ready late, response next cycle.
    cyc();
    idle_bus();
    mem_wea = 1'b1;
    mem_en = 4'hF;
    mem_addr = 32'hF000_0004;
    mem_din = 32'hA5A5_0001;
    exp_q.push_back(32'h0);
    #1;
    check("mw_hold0", a_hold, 1);
    check("mw_ram_en", a_ram_en, 0);
    vcnt = 0;
    resp_c = 0;
    for (int c = 1; c <= 10 && resp_c == 0; c++) begin
      cyc();
      mmio_req_ready = (c == 4);
      mmio_rsp_valid = (c == 5);
      mmio_rdata = 32'h7777_7777;
      #1;
      if (c == 1 || c == 4) begin
        check("mw_addr", a_mmio_addr, 8'h04);
        check("mw_we", a_mmio_we, 1);
        check("mw_wdata", a_mmio_wdata,
              32'hA5A5_0001);
        check("mw_be", a_mmio_be, 4'hF);
      end
      vcnt += int'(a_req_valid);
      if (!a_hold) resp_c = c;
    end
    check("mw_valid_cycles", vcnt, 4);
    check("mw_resp_cycle", resp_c, 6);
    expv = exp_q.pop_front();
    check("mw_dout", a_dout, expv);
    check("mw_err", a_err, 0);

    // MMIO read, minimum turnaround.
    cyc();
    idle_bus();
    mem_rea = 1'b1;
    mem_en = 4'hF;
    mem_addr = 32'hF000_000C;
    exp_q.push_back(32'h1357_9BDF);
    #1;
    resp_c = 0;
    for (int c = 1; c <= 10 && resp_c == 0; c++) begin
      cyc();
      mmio_req_ready = (c == 1);
      mmio_rsp_valid = (c == 2);
      mmio_rdata = 32'h1357_9BDF;
      #1;
      if (c == 1) check("mr_we", a_mmio_we, 0);
      if (!a_hold) resp_c = c;
    end
    check("mr_resp_cycle", resp_c, 3);
    expv = exp_q.pop_front();
    check("mr_dout", a_dout, expv);

    // MMIO read with no response: timeout.
    cyc();
    idle_bus();
    mem_rea = 1'b1;
    mem_en = 4'hF;
    mem_addr = 32'hF000_0008;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    resp_c = 0;
    err_c = 0;
    err_n = 0;
    for (int c = 1; c <= TO + 40 && resp_c == 0;
         c++) begin
      cyc();
      mmio_req_ready = (c == 1);
      #1;
      if (a_err) begin
        err_n++;
        err_c = c;
      end
      if (!a_hold) resp_c = c;
    end
    check("to_resp_cycle", resp_c, TO + 2);
    check("to_err_cycle", err_c, TO + 2);
    check("to_valid", a_req_valid, 0);
    expv = exp_q.pop_front();
    check("to_dout", a_dout, expv);
    cyc();
    idle_bus();
    #1;
    err_n += int'(a_err);
    check("to_err_count", err_n, 1);
    check("to_dout_idle", a_dout, 0);

    // Illegal enables and read+write together.
    for (int i = 0; i < 2; i++) begin
      cyc();
      mem_rea = 1'b1;
      mem_wea = (i == 1);
      mem_en = (i == 0) ? 4'b0101 : 4'hF;
      mem_addr = 32'h20;
      #1;
      check("ill_ram_en", a_ram_en, 0);
      check("ill_hold", a_hold, 0);
      check("ill_err_early", a_err, 0);
      cyc();
      idle_bus();
      #1;
      check("ill_err", a_err, 1);
      check("ill_dout", a_dout, 0);
      check("ill_valid", a_req_valid, 0);
      cyc();
      #1;
      check("ill_err_end", a_err, 0);
    end

    // Reset during MMIO_REQ.
    cyc();
    mem_rea = 1'b1;
    mem_en = 4'hF;
    mem_addr = 32'hF000_0010;
    #1;
    cyc();
    #1;
    check("rq_valid", a_req_valid, 1);
    #2;
    Rst = 1'b1;
    #1;
    check("rq_rst_valid", a_req_valid, 0);
    check("rq_rst_hold", a_hold, 0);
    check("rq_rst_err", a_err, 0);
    cyc();
    idle_bus();
    #1;
    check("rq_rst_err2", a_err, 0);
    Rst = 1'b0;
    cyc();
    mem_wea = 1'b1;
    mem_en = 4'hF;
    mem_addr = 32'h30;
    mem_din = 32'h0BAD_F00D;
    #1;
    check("rq_idle_ram_en", a_ram_en, 1);
    check("rq_idle_hold", a_hold, 0);
    check("rq_idle_err", a_err, 0);

    // RD_LAT=1 instance: back-to-back reads.
    cyc();
    idle_bus();
    Rst = 1'b1;
    cyc();
    Rst = 1'b0;
    cyc();
    mem_rea = 1'b1;
    mem_en = 4'hF;
    mem_addr = 32'h0;
    exp_q.push_back(32'h1111_2222);
    #1;
    wait_resp(1'b1, holds, ens);
    check("rd1_holds", holds, 2);
    check("rd1_ram_en", ens, 1);
    expv = exp_q.pop_front();
    check("rd1_dout", b_dout, expv);
    cyc();
    mem_addr = 32'h4;
    exp_q.push_back(32'h3333_4444);
    #1;
    wait_resp(1'b1, holds, ens);
    check("rd1b_holds", holds, 2);
    check("rd1b_ram_en", ens, 1);
    expv = exp_q.pop_front();
    check("rd1b_dout", b_dout, expv);
    cyc();
    idle_bus();
    #1;
    check("rd1_dout_idle", b_dout, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
